// File: rtl/mac_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : mac_result_collector
// Description : Captures mac results LATENCY cycles after issue, rounds,
//               shifts and saturates them, then buffers them in a credit-
//               protected FIFO drained through a valid/ready interface.
// Revision    : 1.0  initial release
// ============================================================================
module mac_result_collector #(
    parameter int ACC_WIDTH  = 34,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 4,
    parameter int LATENCY    = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 arst_in,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic [ACC_WIDTH-1:0] mac_out,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [OUT_WIDTH-1:0] res_data,
    output logic                 res_sat,
    output logic [15:0]          sat_count
);

    generate
        if (LATENCY < 1) begin : g_chk_latency
            $error("mac_result_collector: LATENCY must be >= 1");
        end
        if (FIFO_DEPTH < 2) begin : g_chk_depth
            $error("mac_result_collector: FIFO_DEPTH must be >= 2");
        end
        if (OUT_WIDTH > ACC_WIDTH) begin : g_chk_width
            $error("mac_result_collector: OUT_WIDTH must not exceed ACC_WIDTH");
        end
    endgenerate

    localparam int c_pw = $clog2(FIFO_DEPTH);
    localparam int c_cw = $clog2(FIFO_DEPTH + 1);
    localparam int c_tw = $clog2(FIFO_DEPTH + LATENCY + 1);

    localparam logic signed [ACC_WIDTH:0] c_rnd = ((ACC_WIDTH+1)'(1) << SHIFT) >> 1;
    localparam logic signed [ACC_WIDTH:0] c_max = ((ACC_WIDTH+1)'(1) << (OUT_WIDTH-1)) - (ACC_WIDTH+1)'(1);
    localparam logic signed [ACC_WIDTH:0] c_min = ~c_max;

    logic [LATENCY-1:0]     r_delay;
    logic [c_pw-1:0]        r_wr;
    logic [c_pw-1:0]        r_rd;
    logic [c_cw-1:0]        r_count;
    logic [15:0]            r_sat_count;
    logic [OUT_WIDTH:0]     r_mem [FIFO_DEPTH];

    logic                   w_fire;
    logic                   w_push;
    logic                   w_pop;
    logic [c_tw-1:0]        w_inflight;
    logic [c_tw-1:0]        w_total;
    logic signed [ACC_WIDTH:0] w_ext;
    logic signed [ACC_WIDTH:0] w_shr;
    logic [OUT_WIDTH-1:0]   w_narrow;
    logic                   w_sat;

    // Credit covers both buffered and in-flight results, so a push can never
    // find the FIFO full even though mac cannot be stalled.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            w_inflight = w_inflight + c_tw'(r_delay[i]);
        end
    end

    assign w_total     = c_tw'(r_count) + w_inflight;
    assign issue_ready = !arst_in && (w_total < c_tw'(FIFO_DEPTH));
    assign w_fire      = issue_valid & issue_ready;
    assign w_push      = r_delay[LATENCY-1];
    assign w_pop       = res_valid & res_ready;

    assign w_ext = $signed({mac_out[ACC_WIDTH-1], mac_out}) + c_rnd;
    assign w_shr = w_ext >>> SHIFT;

    always_comb begin
        w_sat    = 1'b0;
        w_narrow = w_shr[OUT_WIDTH-1:0];
        if (w_shr > c_max) begin
            w_sat    = 1'b1;
            w_narrow = c_max[OUT_WIDTH-1:0];
        end else if (w_shr < c_min) begin
            w_sat    = 1'b1;
            w_narrow = c_min[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            r_delay     <= '0;
            r_wr        <= '0;
            r_rd        <= '0;
            r_count     <= '0;
            r_sat_count <= '0;
        end else begin
            r_delay <= (r_delay << 1) | LATENCY'(w_fire);
            if (w_push) begin
                r_wr <= (r_wr == c_pw'(FIFO_DEPTH-1)) ? '0 : r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= (r_rd == c_pw'(FIFO_DEPTH-1)) ? '0 : r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_sat && (r_sat_count != 16'hFFFF)) begin
                r_sat_count <= r_sat_count + 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= {w_sat, w_narrow};
        end
    end

    assign res_valid            = (r_count != '0);
    assign {res_sat, res_data}  = res_valid ? r_mem[r_rd] : '0;
    assign sat_count            = r_sat_count;

endmodule
`default_nettype wire

// File: tb/tb_mac_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_result_collector
// Description : Scoreboard bench for mac_result_collector with a mac stand-in
//               that presents each issued operand result LATENCY edges later.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mac_result_collector;

    localparam int ACC_W  = 34;
    localparam int OUT_W  = 16;
    localparam int SHIFT  = 4;
    localparam int LAT    = 3;
    localparam int DEPTH  = 8;

    logic             clk = 1'b0;
    logic             arst_in;
    logic             issue_valid;
    logic             issue_ready;
    logic [ACC_W-1:0] mac_out;
    logic             res_valid;
    logic             res_ready;
    logic [OUT_W-1:0] res_data;
    logic             res_sat;
    logic [15:0]      sat_count;

    mac_result_collector #(
        .ACC_WIDTH (ACC_W),
        .OUT_WIDTH (OUT_W),
        .SHIFT     (SHIFT),
        .LATENCY   (LAT),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .arst_in    (arst_in),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .mac_out    (mac_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_sat    (res_sat),
        .sat_count  (sat_count)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    int            fires  = 0;
    int            npops  = 0;
    longint        nv     = 0;
    logic [16:0]   sb[$];
    longint        plan[int];
    logic          hold_prev = 1'b0;
    logic [16:0]   prev_head;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: round half up as floor((m + half) / 2^SHIFT), then clamp.
    function automatic logic [16:0] model(input longint m);
        longint half, r, hi, lo;
        logic [63:0] rb;
        half = (longint'(1) << SHIFT) / 2;
        r    = (m + half) >>> SHIFT;
        hi   = (longint'(1) << (OUT_W-1)) - 1;
        lo   = -(longint'(1) << (OUT_W-1));
        if (r > hi) return {1'b1, 16'h7FFF};
        if (r < lo) return {1'b1, 16'h8000};
        rb = r;
        return {1'b0, rb[15:0]};
    endfunction

    function automatic longint rnd_val();
        longint x;
        case ($urandom_range(0, 3))
            0: x = longint'($urandom_range(0, 2097152)) - 1048576;
            1: begin
                x = {$urandom, $urandom};
                x = (x <<< 30) >>> 30;
            end
            2: x = 524280 + longint'($urandom_range(0, 16)) - 8;
            default: x = -524289 + longint'($urandom_range(0, 16)) - 8;
        endcase
        return x;
    endfunction

    // One clock: record an issue at the negedge, advance, then drive mac_out.
    task automatic step();
        logic [63:0] mv;
        @(negedge clk);
        if (issue_valid && issue_ready) begin
            fires++;
            plan[cyc + LAT + 1] = nv;
            sb.push_back(model(nv));
        end
        @(posedge clk);
        cyc++;
        #1;
        if (plan.exists(cyc + 1)) mv = plan[cyc + 1];
        else mv = {$urandom, $urandom};
        mac_out = mv[ACC_W-1:0];
    endtask

    task automatic issue_one(input longint v);
        issue_valid = 1'b1;
        nv = v;
        step();
        issue_valid = 1'b0;
    endtask

    task automatic drain();
        res_ready = 1'b1;
        issue_valid = 1'b0;
        for (int k = 0; k < 60 && sb.size() != 0; k++) step();
        chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: compares every popped head against the scoreboard.
    always @(negedge clk) begin
        if (arst_in) begin
            hold_prev <= 1'b0;
        end else begin
            if (!res_valid) begin
                chk("empty_data_zero", {47'd0, res_sat, res_data}, 64'd0);
            end
            if (hold_prev && res_valid) begin
                chk("head_stable", {47'd0, res_sat, res_data}, {47'd0, prev_head});
            end
            if (res_valid && res_ready) begin
                npops++;
                if (sb.size() == 0) begin
                    chk("unexpected_result", {47'd0, res_sat, res_data}, 64'hDEAD);
                end else begin
                    chk("result", {47'd0, res_sat, res_data}, {47'd0, sb.pop_front()});
                end
            end
            hold_prev <= res_valid && !res_ready;
            prev_head <= {res_sat, res_data};
        end
    end

    initial begin
        int drops;
        int p0;
        arst_in     = 1'b1;
        issue_valid = 1'b0;
        res_ready   = 1'b1;
        mac_out     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_issue_ready", 64'(issue_ready), 64'd0);
        chk("rst_res_valid",   64'(res_valid),   64'd0);
        chk("rst_res_data",    64'(res_data),    64'd0);
        chk("rst_res_sat",     64'(res_sat),     64'd0);
        chk("rst_sat_count",   64'(sat_count),   64'd0);
        arst_in = 1'b0;
        #1;
        chk("ready_after_release", 64'(issue_ready), 64'd1);

        // Latency: valid appears only after the third edge following issue.
        issue_one(64'h1234);
        chk("lat_valid_e0", 64'(res_valid), 64'd0);
        step();
        chk("lat_valid_e1", 64'(res_valid), 64'd0);
        step();
        chk("lat_valid_e2", 64'(res_valid), 64'd0);
        step();
        chk("lat_valid_e3", 64'(res_valid), 64'd1);
        chk("lat_data",     64'(res_data),  64'h0123);
        drain();

        issue_one(24);
        issue_one(-24);
        issue_one(-8);
        drain();

        issue_one(longint'(1) << 24);
        issue_one(-(longint'(1) << 24));
        drain();
        chk("sat_count_two", 64'(sat_count), 64'd2);

        issue_one(524279);
        issue_one(524280);
        issue_one(-524288);
        issue_one(-524289);
        issue_one(-524297);
        issue_one((longint'(1) << 33) - 1);
        issue_one(-(longint'(1) << 33));
        drain();
        chk("sat_count_six", 64'(sat_count), 64'd6);

        // Backpressure: credit must stop issue after exactly DEPTH fires.
        res_ready = 1'b0;
        fires = 0;
        for (int k = 0; k < 20; k++) begin
            issue_valid = 1'b1;
            nv = rnd_val();
            step();
        end
        issue_valid = 1'b0;
        chk("bp_fires", 64'(fires), 64'(DEPTH));
        chk("bp_ready_low", 64'(issue_ready), 64'd0);
        drain();
        chk("bp_ready_back", 64'(issue_ready), 64'd1);

        // Throughput: one issue and one result per cycle, no credit stall.
        res_ready = 1'b1;
        drops = 0;
        fires = 0;
        p0 = npops;
        for (int i = 0; i < 100; i++) begin
            if (!issue_ready) drops++;
            issue_valid = 1'b1;
            nv = 16 * longint'(fires);
            step();
        end
        issue_valid = 1'b0;
        chk("tp_no_drop", 64'(drops), 64'd0);
        chk("tp_fires", 64'(fires), 64'd100);
        repeat (3) step();
        chk("tp_pops_103", 64'(npops - p0), 64'd99);
        step();
        chk("tp_pops_104", 64'(npops - p0), 64'd100);
        drain();

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            issue_valid = ($urandom_range(0, 3) != 0);
            res_ready   = ($urandom_range(0, 2) != 0);
            nv = rnd_val();
            step();
        end
        drain();

        // Reset with two buffered and three in flight.
        res_ready = 1'b0;
        issue_one(100);
        issue_one(200);
        repeat (3) step();
        issue_one(300);
        issue_one(400);
        issue_one(500);
        chk("mid_buffered", 64'(res_valid), 64'd1);
        arst_in = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(res_valid), 64'd0);
        chk("mid_rst_ready", 64'(issue_ready), 64'd0);
        sb.delete();
        plan.delete();
        step();
        step();
        arst_in = 1'b0;
        #1;
        chk("mid_ready_release", 64'(issue_ready), 64'd1);
        res_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("mid_no_stale", 64'(res_valid), 64'd0);
        end
        issue_one(-1000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
